// File: rtl/l2_flush_ctrl.sv
// L2 flush walker: reads every set/way tag, issues evictions for valid lines,
// bounds in-flight evictions and drains them before signalling completion.
module l2_flush_ctrl #(
  parameter int L2_SETS = 256,
  parameter int L2_WAYS = 8,
  parameter int N_REQS  = 4,
  localparam int SW = $clog2(L2_SETS),
  localparam int WW = $clog2(L2_WAYS),
  localparam int OW = $clog2(N_REQS) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_req,
  output logic          flush_busy,
  output logic          flush_done,
  output logic          rd_valid,
  output logic [SW-1:0] rd_set,
  output logic [WW-1:0] rd_way,
  input  logic          line_valid,
  input  logic          line_dirty,
  output logic          evict_valid,
  input  logic          evict_ready,
  output logic [SW-1:0] evict_set,
  output logic [WW-1:0] evict_way,
  output logic          evict_dirty,
  input  logic          req_done,
  output logic [OW-1:0] outstanding
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  localparam logic [SW:0]   LSET = (SW+1)'(L2_SETS - 1);
  localparam logic [WW-1:0] LWAY = WW'(L2_WAYS - 1);
  localparam logic [OW-1:0] NMAX = OW'(N_REQS);

  state_e        state_q, state_d;
  logic [SW:0]   set_q, set_d;
  logic [WW-1:0] way_q, way_d;
  logic [OW-1:0] out_q, out_d;
  logic          dirty_q, dirty_d;
  logic          rdv_q, evv_q, done_q, busy_q;
  logic [SW-1:0] aset_q;
  logic [WW-1:0] away_q;
  logic          accept, retire, adv, last;

  assign accept = evv_q & evict_ready;
  assign retire = req_done & (out_q != '0);
  assign last   = (set_q == LSET) && (way_q == LWAY);

  always_comb begin
    state_d = state_q;
    set_d   = set_q;
    way_d   = way_q;
    dirty_d = dirty_q;
    out_d   = out_q;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          set_d   = '0;
          way_d   = '0;
          state_d = READ;
        end
      end
      READ:  state_d = CHECK;
      CHECK: begin
        if (line_valid) begin
          dirty_d = line_dirty;
          state_d = ISSUE;
        end else begin
          adv = 1'b1;
        end
      end
      ISSUE: adv = accept;
      DRAIN: if (out_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (way_q == LWAY) begin
        way_d = '0;
        set_d = set_q + 1'b1;
      end else begin
        way_d = way_q + 1'b1;
      end
      state_d = last ? DRAIN : READ;
    end
    if (accept && !retire) begin
      out_d = out_q + 1'b1;
    end else if (!accept && retire) begin
      out_d = out_q - 1'b1;
    end
  end

  // Outputs are flops loaded from next-state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      out_q   <= '0;
      dirty_q <= 1'b0;
      rdv_q   <= 1'b0;
      evv_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      aset_q  <= '0;
      away_q  <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      out_q   <= out_d;
      dirty_q <= dirty_d;
      rdv_q   <= (state_d == READ);
      evv_q   <= (state_d == ISSUE) && (out_d < NMAX);
      done_q  <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
      aset_q  <= set_d[SW-1:0];
      away_q  <= way_d;
    end
  end

  assign flush_busy  = busy_q;
  assign flush_done  = done_q;
  assign rd_valid    = rdv_q;
  assign rd_set      = aset_q;
  assign rd_way      = away_q;
  assign evict_valid = evv_q;
  assign evict_set   = aset_q;
  assign evict_way   = away_q;
  assign evict_dirty = dirty_q;
  assign outstanding = out_q;

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// Bench for l2_flush_ctrl: table of flush scenarios plus random flushes,
// scored against a line-list / in-flight-count model.
module tb_l2_flush_ctrl;

  localparam int SETS = 4;
  localparam int WAYS = 2;
  localparam int NR   = 2;
  localparam int L    = SETS * WAYS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush_req = 1'b0;
  logic       flush_busy, flush_done, rd_valid;
  logic [1:0] rd_set, evict_set;
  logic [0:0] rd_way, evict_way;
  logic       line_valid = 1'b0;
  logic       line_dirty = 1'b0;
  logic       evict_valid, evict_dirty;
  logic       evict_ready = 1'b0;
  logic       req_done = 1'b0;
  logic [1:0] outstanding;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int coin  = 0;

  always #5 clk = ~clk;

  l2_flush_ctrl #(
    .L2_SETS(SETS),
    .L2_WAYS(WAYS),
    .N_REQS (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .rd_valid   (rd_valid),
    .rd_set     (rd_set),
    .rd_way     (rd_way),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .evict_valid(evict_valid),
    .evict_ready(evict_ready),
    .evict_set  (evict_set),
    .evict_way  (evict_way),
    .evict_dirty(evict_dirty),
    .req_done   (req_done),
    .outstanding(outstanding)
  );

  typedef struct {
    logic [7:0] vm;
    logic [7:0] dm;
    int         rm;
    int         dly;
    int         nev;
    int         ndt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({flush_busy, flush_done, rd_valid, rd_set, rd_way,
                evict_valid, evict_set, evict_way, evict_dirty,
                outstanding});
  endfunction

  // rm: 0 ready=1, 1 random ready, 2 stall 5 cycles, 4 reset at line 2
  task automatic run_flush(input logic [7:0] vm, input logic [7:0] dm,
                           input int rm, input int dly,
                           output int nev, output int ndt);
    int         rd_idx, exp_out, stall, prev_a, d;
    int         due[$];
    int         evq[$];
    logic       prev_rd, prev_st, acc, fin;
    logic [31:0] ra, ev;
    rd_idx = 0; exp_out = 0; stall = 0; prev_a = 0;
    prev_rd = 0; prev_st = 0; fin = 0;
    nev = 0; ndt = 0;
    for (int i = 0; i < L; i++)
      if (vm[i]) evq.push_back(i * 2 + int'(dm[i]));
    flush_req = 1'b1;
    evict_ready = 1'b0;
    req_done = 1'b0;
    for (int t = 0; t < 800 && !fin; t++) begin
      step();
      ra = 32'({rd_set, rd_way});
      ev = 32'({evict_set, evict_way, evict_dirty});
      chk("outstanding", 32'(outstanding), exp_out);
      chk("busy", 32'(flush_busy), 1);
      if (prev_rd) begin
        line_valid = vm[prev_a];
        line_dirty = dm[prev_a];
      end else begin
        line_valid = 1'($urandom);
        line_dirty = 1'($urandom);
      end
      if (rd_valid) begin
        chk("rd_addr", ra, rd_idx);
        rd_idx++;
      end
      if (prev_st) chk("ev_hold", 32'(evict_valid), 1);
      if (exp_out >= NR) chk("ev_full", 32'(evict_valid), 0);
      if (evict_valid)
        chk("ev_line", ev, evq.size() > 0 ? evq[0] : -1);
      if (rm == 4 && evict_valid && ev[3:1] == 3'd2) begin
        flush_req = 1'b0;
        evict_ready = 1'b0;
        req_done = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_outs", all_outs(), 0);
        for (int k = 0; k < 10; k++) begin
          step();
          rst = 1'b0;
          chk("rst_quiet", 32'({flush_busy, flush_done, rd_valid,
                                evict_valid, outstanding}), 0);
        end
        return;
      end
      unique case (rm)
        1:       evict_ready = 1'($urandom);
        2:       evict_ready = (stall >= 5);
        default: evict_ready = 1'b1;
      endcase
      if (evict_valid) stall++;
      acc = evict_valid && evict_ready;
      if (acc) begin
        if (evq.size() > 0) void'(evq.pop_front());
        nev++;
        ndt += int'(evict_dirty);
        stall = 0;
        d = (dly < 0) ? $urandom_range(1, 6) : dly;
        due.push_back(cyc + d);
      end
      req_done = 1'b0;
      if (due.size() > 0 && due[0] <= cyc) begin
        req_done = 1'b1;
        void'(due.pop_front());
      end else if (rm == 1 && exp_out == 0 && $urandom_range(0, 3) == 0) begin
        req_done = 1'b1;
      end
      if (req_done && acc && exp_out > 0) coin++;
      exp_out = exp_out + int'(acc) - int'(req_done && exp_out > 0);
      if (flush_done) begin
        chk("done_out", 32'(outstanding), 0);
        chk("done_due", due.size(), 0);
        chk("done_reads", rd_idx, L);
        chk("done_evq", evq.size(), 0);
        fin = 1;
        flush_req = 1'b0;
      end else begin
        flush_req = (rd_idx == L) ? 1'b1 : ($urandom_range(0, 7) == 0);
      end
      prev_st = evict_valid && !evict_ready;
      prev_rd = rd_valid;
      prev_a = int'(ra);
    end
    if (!fin) chk("timeout", 0, 1);
    evict_ready = 1'b0;
    step();
    chk("idle_busy", 32'({flush_busy, flush_done, rd_valid, evict_valid}), 0);
    chk("idle_out", 32'(outstanding), exp_out);
    req_done = 1'b1;
    step();
    req_done = 1'b0;
    chk("no_underflow", 32'(outstanding), 0);
    chk("no_restart", 32'({flush_busy, rd_valid}), 0);
  endtask

  initial begin
    int nev, ndt;
    logic [7:0] vm, dm;
    tbl[0] = '{8'h00, 8'hFF, 0, 2, 0, 0};
    tbl[1] = '{8'hFF, 8'h00, 0, 2, 8, 0};
    tbl[2] = '{8'h20, 8'h20, 2, 2, 1, 1};
    tbl[3] = '{8'hFF, 8'hA5, 0, 3, 8, 4};
    tbl[4] = '{8'hFF, 8'h0F, 0, 9, 8, 4};
    tbl[5] = '{8'hFF, 8'h00, 4, 2, 2, 0};
    tbl[6] = '{8'h81, 8'h01, 1, -1, 2, 1};
    tbl[7] = '{8'h3C, 8'hF0, 1, -1, 4, 2};

    #12;
    chk("reset_outs", all_outs(), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_reset", all_outs(), 0);

    for (int i = 0; i < 8; i++) begin
      run_flush(tbl[i].vm, tbl[i].dm, tbl[i].rm, tbl[i].dly, nev, ndt);
      chk($sformatf("tbl%0d_nev", i), nev, tbl[i].nev);
      chk($sformatf("tbl%0d_ndt", i), ndt, tbl[i].ndt);
    end

    for (int i = 0; i < 6; i++) begin
      vm = 8'($urandom);
      dm = 8'($urandom);
      run_flush(vm, dm, 1, -1, nev, ndt);
      chk("rnd_nev", nev, $countones(vm));
      chk("rnd_ndt", ndt, $countones(vm & dm));
    end

    chk("coincide_seen", 32'(coin > 0), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_flush_ctrl.md
L2_FLUSH_CTRL -- requirements
Module: l2_flush_ctrl

Interface
REQ-001 SHALL have parameter L2_SETS, default 256, number of sets; power of 2, >=2.
REQ-002 SHALL have parameter L2_WAYS, default 8, number of ways; power of 2, >=2.
REQ-003 SHALL have parameter N_REQS, default 4, maximum outstanding evictions.
REQ-004 SHALL have port clk  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush_req  in  1  single-cycle flush start pulse.
REQ-007 SHALL have port flush_busy  out  1  high while any flush is in progress.
REQ-008 SHALL have port flush_done  out  1  single-cycle completion pulse.
REQ-009 SHALL have port rd_valid  out  1  tag-array read strobe.
REQ-010 SHALL have port rd_set  out  log2(L2_SETS)  set under test.
REQ-011 SHALL have port rd_way  out  log2(L2_WAYS)  way under test.
REQ-012 SHALL have port line_valid  in  1  tag state of the read line, one cycle after rd_valid.
REQ-013 SHALL have port line_dirty  in  1  dirty state of the read line, same timing as line_valid.
REQ-014 SHALL have port evict_valid  out  1  eviction request valid.
REQ-015 SHALL have port evict_ready  in  1  eviction request accepted.
REQ-016 SHALL have port evict_set  out  log2(L2_SETS)  eviction set.
REQ-017 SHALL have port evict_way  out  log2(L2_WAYS)  eviction way.
REQ-018 SHALL have port evict_dirty  out  1  line_dirty captured for the eviction.
REQ-019 SHALL have port req_done  in  1  single-cycle retirement of one outstanding eviction.
REQ-020 SHALL have port outstanding  out  log2(N_REQS)+1  in-flight eviction count.

Function
REQ-021 SHALL implement the states IDLE, READ, CHECK, ISSUE, DRAIN and DONE.
REQ-022 IDLE: flush_req SHALL clear the set/way counters and move to READ; flush_req in any other state SHALL be ignored.
REQ-023 READ: rd_valid=1 for exactly one cycle with rd_set/rd_way = the counters; next state CHECK.
REQ-024 CHECK: SHALL sample line_valid/line_dirty; valid -> capture dirty into evict_dirty and go to ISSUE; invalid -> advance.
REQ-025 ISSUE: evict_valid SHALL be 1 iff outstanding < N_REQS; evict_set/evict_way/evict_dirty SHALL stay stable while evict_valid=1 and evict_ready=0.
REQ-026 On an evict_valid and evict_ready cycle: outstanding +1, then advance.
REQ-027 Advance: way+1; at way=L2_WAYS-1, way=0 and set+1; after set=L2_SETS-1 and way=L2_WAYS-1 -> DRAIN, else -> READ.
REQ-028 Set counter SHALL be log2(L2_SETS)+1 bits wide so terminal detection does not alias on wrap-around.
REQ-029 DRAIN: SHALL remain until outstanding==0, then go to DONE.
REQ-030 DONE: flush_done=1 for one cycle, then IDLE.
REQ-031 req_done SHALL decrement outstanding in any state.
REQ-032 A same-cycle accept and req_done SHALL leave outstanding unchanged.
REQ-033 req_done with outstanding==0 SHALL be ignored (no underflow).
REQ-034 flush_busy SHALL be 1 in every state except IDLE.
REQ-035 All outputs SHALL be registered; rd_valid, evict_valid and flush_done SHALL be 0 outside their states.

Reset
REQ-036 rst SHALL asynchronously force IDLE, counters=0, outstanding=0, and all outputs to 0.
REQ-037 rst asserted mid-flush SHALL abandon the walk; no further evict_valid or flush_done until the next flush_req.

Verification (L2_SETS=4, L2_WAYS=2, N_REQS=2)
REQ-038 All lines invalid, flush_req -> 8 rd_valid pulses (set,way 0,0 .. 3,1), no evict_valid, then flush_done, flush_busy low.
REQ-039 All lines valid, evict_ready=1, req_done 2 cycles after each accept -> 8 evictions in set/way order, outstanding never >2, flush_done only after the last req_done.
REQ-040 Line (2,1) dirty, evict_ready held 0 for 5 cycles -> evict_set=2, evict_way=1, evict_dirty=1 stable for all 5 cycles.
REQ-041 outstanding=2, no req_done -> evict_valid stays 0; accept coinciding with req_done -> outstanding stays at its value.
REQ-042 rst pulse during ISSUE at (1,0) -> all outputs 0 immediately; flush_req 10 cycles later restarts the walk at (0,0).
REQ-043 flush_req during DRAIN and req_done at outstanding=0 -> no restart, outstanding remains 0.
